// File: rtl/tx_queue_pkg.sv
// tx_queue_pkg: shared state encoding, packet field layout and helpers for the
// data_tx_queue egress path.
package tx_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } tx_state_t;

    localparam int PKT_VALID_BIT = 31;
    localparam int PKT_DEST_MSB  = 30;
    localparam int PKT_DEST_LSB  = 16;

    typedef struct packed {
        logic                             valid;
        logic [PKT_DEST_MSB-PKT_DEST_LSB:0] dest;
        logic [PKT_DEST_LSB-1:0]          payload;
    } tx_packet_t;

    function automatic logic pkt_valid(input logic [31:0] word);
        return word[PKT_VALID_BIT];
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: circular packet store; pointers carry one extra wrap bit so a full
// buffer and an empty buffer are distinguishable.
module tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      head,
    output logic                   push_ok,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              pop_ok;
    logic [DATA_W-1:0] mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push is accepted even when full.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/data_tx_queue.sv
// data_tx_queue: captures computer packets into tx_fifo and transmits each with a
// req/gnt + ack handshake, retrying on timeout. DATA_TX_QUEUE_STATS_EN adds counters.
module data_tx_queue
    import tx_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16,
    parameter int MAX_RETRY   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            packet_in,
    output logic                   link_req,
    input  logic                   link_gnt,
    output logic [31:0]            link_packet,
    output logic                   link_valid,
    input  logic                   link_ack,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   drop
`ifdef DATA_TX_QUEUE_STATS_EN
    ,
    output logic [15:0]            stat_sent,
    output logic [15:0]            stat_retry,
    output logic [15:0]            stat_drop
`endif
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LOAD  = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [RW-1:0] RETRY_ONE   = RW'(1);

    tx_packet_t    cap_pkt;
    tx_packet_t    prev;
    tx_packet_t    head;
    logic          capture;
    logic          push_ok;
    logic          pop;
    logic          ack_hit;
    logic          timeout;
    logic          give_up;
    tx_state_t     state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry_cnt;

    // Capture stage: a held word from the computer is taken only on its first cycle.
    assign cap_pkt = tx_packet_t'(packet_in);
    assign capture = pkt_valid(packet_in) && (cap_pkt != prev);

    // Ack has priority over the timeout that would otherwise fire in the same cycle.
    assign ack_hit = (state == WAIT) && link_ack;
    assign timeout = (state == WAIT) && !link_ack && (timer == TIMER_LAST);
    assign give_up = timeout && (retry_cnt == RETRY_LIMIT);
    assign pop     = ack_hit || give_up;

    tx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(tx_packet_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (capture),
        .pop     (pop),
        .din     (cap_pkt),
        .head    (head),
        .push_ok (push_ok),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev     <= '0;
            overflow <= 1'b0;
        end else begin
            prev     <= cap_pkt;
            overflow <= capture && !push_ok;
        end
    end

    // Transmit stage: the head stays in the FIFO until acked or dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            link_req    <= 1'b0;
            link_valid  <= 1'b0;
            link_packet <= '0;
            drop        <= 1'b0;
            timer       <= '0;
            retry_cnt   <= '0;
        end else begin
            link_valid <= 1'b0;
            drop       <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state    <= REQ;
                        link_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (link_gnt) begin
                        state       <= SEND;
                        link_req    <= 1'b0;
                        link_valid  <= 1'b1;
                        link_packet <= head;
                    end
                end
                SEND: begin
                    timer <= TIMER_LOAD;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer - TIMER_ONE;
                    if (ack_hit) begin
                        retry_cnt <= '0;
                        state     <= IDLE;
                    end else if (give_up) begin
                        drop      <= 1'b1;
                        retry_cnt <= '0;
                        state     <= IDLE;
                    end else if (timeout) begin
                        retry_cnt <= retry_cnt + RETRY_ONE;
                        link_req  <= 1'b1;
                        state     <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    link_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef DATA_TX_QUEUE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_sent  <= '0;
            stat_retry <= '0;
            stat_drop  <= '0;
        end else begin
            if (ack_hit)             stat_sent  <= sat_inc(stat_sent);
            if (timeout && !give_up) stat_retry <= sat_inc(stat_retry);
            if (give_up)             stat_drop  <= sat_inc(stat_drop);
        end
    end
`endif

endmodule

// File: tb/tb_data_tx_queue.sv
// tb_data_tx_queue: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level queue model of the egress buffer.
module tb_data_tx_queue;
    localparam int DEPTH       = 8;
    localparam int ACK_TIMEOUT = 16;
    localparam int MAX_RETRY   = 3;

    logic        clk;
    logic        rst;
    logic [31:0] packet_in;
    logic        link_req;
    logic        link_gnt;
    logic [31:0] link_packet;
    logic        link_valid;
    logic        link_ack;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        drop;

    data_tx_queue #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .packet_in   (packet_in),
        .link_req    (link_req),
        .link_gnt    (link_gnt),
        .link_packet (link_packet),
        .link_valid  (link_valid),
        .link_ack    (link_ack),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .drop        (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_drop_seen = 0;
    int n_ovf_seen  = 0;

    // Reference model: packet queue, last input word, and the progress of the head packet.
    logic [31:0] m_q[$];
    logic [31:0] m_prev;
    bit          m_busy;
    bit          m_req;
    int          since;
    int          tries;
    bit          e_valid, e_drop, e_ovf;
    logic [31:0] e_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev  = '0;
        m_busy  = 0;
        m_req   = 0;
        since   = -1;
        tries   = 0;
        e_valid = 0;
        e_drop  = 0;
        e_ovf   = 0;
        e_word  = '0;
    endtask

    task automatic model_edge(input logic [31:0] pin, input bit g, input bit a);
        bit cap, pop, retry, room, n_req;
        cap   = pin[31] && (pin != m_prev);
        m_prev = pin;
        pop   = 0;
        retry = 0;
        n_req = 0;
        e_valid = 0;
        e_drop  = 0;
        if (since >= 1) begin
            if (a) begin
                pop = 1;
            end else if (since == ACK_TIMEOUT) begin
                if (tries > MAX_RETRY) begin
                    pop    = 1;
                    e_drop = 1;
                end else begin
                    retry = 1;
                end
                since = -1;
            end
        end
        if (pop) since = -1;
        else if (since >= 0) since++;
        if (m_req) begin
            if (g) begin
                e_valid = 1;
                e_word  = m_q[0];
                tries++;
                since   = 0;
            end else begin
                n_req = 1;
            end
        end
        if (retry) n_req = 1;
        if (!m_busy && m_q.size() != 0) begin
            n_req  = 1;
            m_busy = 1;
        end
        room = (m_q.size() < DEPTH) || pop;
        if (pop) begin
            void'(m_q.pop_front());
            tries  = 0;
            m_busy = 0;
        end
        if (cap && room) m_q.push_back(pin);
        e_ovf = cap && !room;
        m_req = n_req;
    endtask

    task automatic tick(input logic [31:0] pin, input bit g, input bit a);
        packet_in = pin;
        link_gnt  = g;
        link_ack  = a;
        model_edge(pin, g, a);
        @(posedge clk);
        #1;
        chk("count", {28'd0, count}, m_q.size());
        chk("empty", {31'd0, empty}, {31'd0, m_q.size() == 0});
        chk("full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
        chk("overflow", {31'd0, overflow}, {31'd0, e_ovf});
        chk("drop", {31'd0, drop}, {31'd0, e_drop});
        chk("link_req", {31'd0, link_req}, {31'd0, m_req});
        chk("link_valid", {31'd0, link_valid}, {31'd0, e_valid});
        if (e_valid) chk("link_packet", link_packet, e_word);
        if (drop === 1'b1) n_drop_seen++;
        if (overflow === 1'b1) n_ovf_seen++;
    endtask

    task automatic chk_reset(input string t);
        chk({t, "_link_req"}, {31'd0, link_req}, 32'd0);
        chk({t, "_link_valid"}, {31'd0, link_valid}, 32'd0);
        chk({t, "_link_packet"}, link_packet, 32'd0);
        chk({t, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({t, "_drop"}, {31'd0, drop}, 32'd0);
        chk({t, "_empty"}, {31'd0, empty}, 32'd1);
        chk({t, "_full"}, {31'd0, full}, 32'd0);
        chk({t, "_count"}, {28'd0, count}, 32'd0);
    endtask

    // Wait (bounded) for a request, grant it, then ack on WAIT cycle ack_at (0 = never).
    task automatic serve(input int ack_at, input logic [31:0] ack_pin, output logic [31:0] word);
        int guard;
        guard = 0;
        while (!m_req && guard < 40) begin
            tick(packet_in, 0, 0);
            guard++;
        end
        chk("serve_req", {31'd0, link_req}, 32'd1);
        tick(packet_in, 1, 0);
        word = link_packet;
        tick(packet_in, 0, 0);
        for (int k = 1; k <= ACK_TIMEOUT; k++) begin
            if (k == ack_at) tick(ack_pin, 0, 1);
            else tick(packet_in, 0, 0);
        end
    endtask

    logic [31:0] w;
    logic [31:0] p;
    logic [31:0] pool [4];
    int          d0, o0, r, gp, ap;

    initial begin
        rst       = 1'b0;
        packet_in = '0;
        link_gnt  = 1'b0;
        link_ack  = 1'b0;
        model_reset();
        #1;
        chk_reset("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single packet held for five cycles.
        for (int i = 0; i < 5; i++) tick(32'h8003_00AA, 0, 0);
        serve(1, packet_in, w);
        chk("single_word", w, 32'h8003_00AA);
        chk("single_empty", {31'd0, empty}, 32'd1);

        // Nine distinct packets with no grant, then drain in order.
        for (int i = 0; i < 9; i++) begin
            tick(32'h8010_0000 + i, 0, 0);
            if (i == 7) chk("ovf_full", {31'd0, full}, 32'd1);
            if (i == 8) chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        end
        tick(packet_in, 0, 0);
        for (int i = 0; i < 8; i++) begin
            serve(3, packet_in, w);
            chk("drain_order", w, 32'h8010_0000 + i);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Never acked: original plus three retries of the same word, then a drop.
        d0 = n_drop_seen;
        tick(32'h8005_1234, 0, 0);
        for (int i = 0; i < 4; i++) begin
            serve(0, packet_in, w);
            chk("retry_word", w, 32'h8005_1234);
        end
        chk("drop_once", n_drop_seen - d0, 32'd1);
        tick(packet_in, 0, 0);
        chk("drop_empty", {31'd0, empty}, 32'd1);

        // Ack lands in the cycle the timeout would expire.
        d0 = n_drop_seen;
        tick(32'h8007_0BEE, 0, 0);
        serve(ACK_TIMEOUT, packet_in, w);
        tick(packet_in, 0, 0);
        chk("ack_last_nodrop", n_drop_seen - d0, 32'd0);
        chk("ack_last_empty", {31'd0, empty}, 32'd1);
        chk("ack_last_noreq", {31'd0, link_req}, 32'd0);

        // Full FIFO: capture and pop in the same cycle.
        for (int i = 0; i < 8; i++) tick(32'h8020_0000 + i, 0, 0);
        chk("simul_full", {31'd0, full}, 32'd1);
        o0 = n_ovf_seen;
        serve(2, 32'h8020_00FF, w);
        chk("simul_word", w, 32'h8020_0000);
        chk("simul_count", {28'd0, count}, 32'd8);
        chk("simul_noovf", n_ovf_seen - o0, 32'd0);

        // Reset during WAIT.
        serve(0, packet_in, w);
        tick(packet_in, 1, 0);
        tick(packet_in, 0, 0);
        tick(packet_in, 0, 0);
        tick(packet_in, 0, 0);
        #2;
        rst       = 1'b0;
        packet_in = '0;
        #1;
        chk_reset("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        tick(32'h0000_0000, 0, 0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);

        // Randomized traffic with alternating grant/ack pressure.
        pool[0] = 32'h8001_0001;
        pool[1] = 32'h8002_0002;
        pool[2] = 32'h8001_0001 ^ 32'h0000_00F0;
        pool[3] = 32'h8004_0004;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(99));
            if (r < 45) p = packet_in;
            else if (r < 70) p = {1'b1, 31'($urandom)};
            else if (r < 85) p = {1'b0, 31'($urandom)};
            else p = pool[$urandom_range(3)];
            gp = ((c / 400) % 2 == 1) ? 60 : 6;
            ap = ((c / 700) % 2 == 1) ? 2 : 12;
            tick(p, int'($urandom_range(99)) < gp, int'($urandom_range(99)) < ap);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
